// File: rtl/seven_seg_scan_ctrl.sv
// Wishbone-programmed scanner for a 4-digit multiplexed 7-segment display.
// Each digit slot is preceded by one blank cycle to avoid ghosting, and the
// segments are PWM-gated by an 8-bit brightness value.
module seven_seg_scan_ctrl #(
   parameter int unsigned DIGITS       = 4,
   parameter logic [15:0] PRESCALE_RST = 16'd999
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              wb_cyc_i,
   input  logic              wb_stb_i,
   input  logic              wb_we_i,
   input  logic [31:0]       wb_adr_i,
   input  logic [31:0]       wb_dat_i,
   input  logic [3:0]        wb_sel_i,
   output logic [31:0]       wb_dat_o,
   output logic              wb_ack_o,
   output logic [7:0]        seven_seg,
   output logic [DIGITS-1:0] digit_en,
   output logic              irq
);

   typedef enum logic [1:0] {StIdle, StBlank, StShow} state_e;

   // Register file
   logic [31:0]       digits_q;
   logic              en_q;
   logic              irq_en_q;
   logic [7:0]        bright_q;
   logic [15:0]       prescale_q;
   logic              frame_done_q;
   logic              ack_q;
   logic [31:0]       dat_q;

   // Scan engine
   state_e            state_q, state_d;
   logic [1:0]        idx_q, idx_d;
   logic [15:0]       slot_q, slot_d;
   logic [7:0]        pwm_q, pwm_d;
   logic [7:0]        seg_q, seg_d;
   logic [DIGITS-1:0] den_q, den_d;
   logic              frame_set;
   logic [15:0]       slot_max;
   logic [7:0]        cur_digit;

   logic              wb_acc;
   logic              wb_wr;
   logic [1:0]        reg_sel;
   logic              status_clr;
   logic [31:0]       rdata;
   logic              unused_adr;

   assign unused_adr = ^{wb_adr_i[31:4], wb_adr_i[1:0]};

   assign reg_sel    = wb_adr_i[3:2];
   // A new access is taken only when no ack is outstanding, so held strobes ack every other cycle.
   assign wb_acc     = wb_cyc_i & wb_stb_i & ~ack_q;
   assign wb_wr      = wb_acc & wb_we_i;
   assign status_clr = wb_wr & (reg_sel == 2'd3) & wb_sel_i[0] & wb_dat_i[0];

   // Read-data mux; unused bits return zero.
   always_comb begin
      rdata = '0;
      unique case (reg_sel)
         2'd0: rdata = digits_q;
         2'd1: rdata = {16'h0, bright_q, 6'h0, irq_en_q, en_q};
         2'd2: rdata = {16'h0, prescale_q};
         2'd3: rdata = {26'h0, idx_q, 3'h0, frame_done_q};
      endcase
   end

   // Wishbone handshake and configuration registers.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         digits_q     <= '0;
         en_q         <= 1'b0;
         irq_en_q     <= 1'b0;
         bright_q     <= '0;
         prescale_q   <= PRESCALE_RST;
         frame_done_q <= 1'b0;
         ack_q        <= 1'b0;
         dat_q        <= '0;
      end else begin
         ack_q <= wb_acc;
         if (wb_acc && !wb_we_i) dat_q <= rdata;
         if (wb_wr) begin
            unique case (reg_sel)
               2'd0: begin
                  for (int b = 0; b < 4; b++) begin
                     if (wb_sel_i[b]) digits_q[8*b +: 8] <= wb_dat_i[8*b +: 8];
                  end
               end
               2'd1: begin
                  if (wb_sel_i[0]) begin
                     en_q     <= wb_dat_i[0];
                     irq_en_q <= wb_dat_i[1];
                  end
                  if (wb_sel_i[1]) bright_q <= wb_dat_i[15:8];
               end
               2'd2: begin
                  if (wb_sel_i[0]) prescale_q[7:0]  <= wb_dat_i[7:0];
                  if (wb_sel_i[1]) prescale_q[15:8] <= wb_dat_i[15:8];
               end
               2'd3: ;
            endcase
         end
         // A frame completing on the same edge as a W1C keeps the flag set.
         if (frame_set)       frame_done_q <= 1'b1;
         else if (status_clr) frame_done_q <= 1'b0;
      end
   end

   // Scan next-state: slot timing, digit advance and frame completion.
   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      slot_d    = slot_q;
      frame_set = 1'b0;
      pwm_d     = pwm_q + 8'd1;
      slot_max  = (prescale_q == 16'd0) ? 16'd1 : prescale_q;
      if (!en_q) begin
         state_d = StIdle;
         idx_d   = '0;
         slot_d  = '0;
      end else begin
         case (state_q)
            StIdle: begin
               state_d = StBlank;
               idx_d   = '0;
               slot_d  = '0;
            end
            StBlank: state_d = StShow;
            StShow: begin
               if (slot_q >= slot_max) begin
                  slot_d    = '0;
                  idx_d     = idx_q + 2'd1;
                  state_d   = StBlank;
                  frame_set = (idx_q == 2'd3);
               end else begin
                  slot_d = slot_q + 16'd1;
               end
            end
            default: state_d = StIdle;
         endcase
      end
   end

   // Display outputs follow the next state so they line up with the registered state.
   always_comb begin
      cur_digit = '0;
      unique case (idx_d)
         2'd0: cur_digit = digits_q[7:0];
         2'd1: cur_digit = digits_q[15:8];
         2'd2: cur_digit = digits_q[23:16];
         2'd3: cur_digit = digits_q[31:24];
      endcase
      seg_d = '0;
      den_d = '0;
      if (state_d == StShow) begin
         den_d = DIGITS'(1) << idx_d;
         if (pwm_d < bright_q) seg_d = cur_digit;
      end
   end

   // Scan FSM state, counters and registered display outputs.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= StIdle;
         idx_q   <= '0;
         slot_q  <= '0;
         pwm_q   <= '0;
         seg_q   <= '0;
         den_q   <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         slot_q  <= slot_d;
         pwm_q   <= pwm_d;
         seg_q   <= seg_d;
         den_q   <= den_d;
      end
   end

   assign wb_ack_o  = ack_q;
   assign wb_dat_o  = dat_q;
   assign seven_seg = seg_q;
   assign digit_en  = den_q;
   assign irq       = frame_done_q & irq_en_q;

endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// Self-checking bench for seven_seg_scan_ctrl: register access, scan sequence,
// PWM, prescale changes, enable/disable, interrupt and reset behaviour.
module tb_seven_seg_scan_ctrl;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        cyc = 1'b0, stb = 1'b0, we = 1'b0;
   logic [31:0] adr = '0, wdat = '0;
   logic [3:0]  sel = '0;
   logic [31:0] rdat;
   logic        ack;
   logic [7:0]  seg;
   logic [3:0]  den;
   logic        irq;

   int          checks = 0;
   int          errors = 0;

   typedef struct {
      logic [3:0] den;
      logic [7:0] seg;
   } exp_t;
   exp_t        sb[$];
   logic        ack_q_exp[$];

   logic [7:0]  tb_pwm;
   logic [7:0]  tb_bright = 8'h00;
   logic [31:0] tb_digits = 32'h3F06_5B4F;

   seven_seg_scan_ctrl #(
      .DIGITS       (4),
      .PRESCALE_RST (16'd999)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .wb_cyc_i  (cyc),
      .wb_stb_i  (stb),
      .wb_we_i   (we),
      .wb_adr_i  (adr),
      .wb_dat_i  (wdat),
      .wb_sel_i  (sel),
      .wb_dat_o  (rdat),
      .wb_ack_o  (ack),
      .seven_seg (seg),
      .digit_en  (den),
      .irq       (irq)
   );

   always #5 clk = ~clk;

   // Free-running 8-bit PWM phase as seen during each cycle.
   always @(posedge clk) begin
      if (!rst_n) tb_pwm <= 8'h00;
      else        tb_pwm <= tb_pwm + 8'h01;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   function automatic logic [7:0] gate(input logic [7:0] d);
      return (tb_pwm < tb_bright) ? d : 8'h00;
   endfunction

   function automatic logic [7:0] dbyte(input int d);
      return 8'(tb_digits >> (8 * d));
   endfunction

   task automatic wb_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
      bit got = 1'b0;
      @(negedge clk);
      cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = a; wdat = d; sel = s;
      for (int i = 0; i < 4 && !got; i++) begin
         @(posedge clk); #1;
         if (ack) got = 1'b1;
      end
      cyc = 1'b0; stb = 1'b0; we = 1'b0;
      checks++;
      if (!got) begin
         errors++;
         $display("FAIL wb_write_ack adr=%h: ack=0 after 4 cycles, required 1", a);
      end
   endtask

   task automatic wb_read(input logic [31:0] a, output logic [31:0] d);
      bit got = 1'b0;
      d = '0;
      @(negedge clk);
      cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = a; sel = 4'hF;
      for (int i = 0; i < 4 && !got; i++) begin
         @(posedge clk); #1;
         if (ack) begin
            got = 1'b1;
            d   = rdat;
         end
      end
      cyc = 1'b0; stb = 1'b0;
      checks++;
      if (!got) begin
         errors++;
         $display("FAIL wb_read_ack adr=%h: ack=0 after 4 cycles, required 1", a);
      end
   endtask

   task automatic test_reset;
      logic [31:0] rd;
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if ({ack, rdat, seg, den, irq} !== 46'h0) begin
         errors++;
         $display("FAIL reset_outputs got ack=%b dat=%h seg=%h den=%b irq=%b, required all 0",
                  ack, rdat, seg, den, irq);
      end
      @(negedge clk);
      rst_n = 1'b1;
      wb_read(32'h0, rd);
      checks++;
      if (rd !== 32'h0) begin errors++; $display("FAIL reset_digits got %h want 0", rd); end
      wb_read(32'h4, rd);
      checks++;
      if (rd !== 32'h0) begin errors++; $display("FAIL reset_ctrl got %h want 0", rd); end
      wb_read(32'h8, rd);
      checks++;
      if (rd !== 32'h3E7) begin errors++; $display("FAIL reset_prescale got %h want 3e7", rd); end
      wb_read(32'hC, rd);
      checks++;
      if (rd !== 32'h0) begin errors++; $display("FAIL reset_status got %h want 0", rd); end
   endtask

   task automatic test_regs;
      logic [31:0] rd;
      wb_write(32'h0, 32'hAABB_CCDD, 4'b0101);
      wb_read(32'h0, rd);
      checks++;
      if (rd !== 32'h00BB_00DD) begin errors++; $display("FAIL sel_digits got %h want 00bb00dd", rd); end
      wb_write(32'h4, 32'hFFFF_FFFE, 4'hF);
      wb_read(32'h4, rd);
      checks++;
      if (rd !== 32'h0000_FF02) begin errors++; $display("FAIL ctrl_unused got %h want 0000ff02", rd); end
      wb_write(32'h4, 32'h0, 4'b0010);
      wb_read(32'h4, rd);
      checks++;
      if (rd !== 32'h2) begin errors++; $display("FAIL sel_ctrl got %h want 2", rd); end
      wb_write(32'h8, 32'hFFFF_1234, 4'b0001);
      wb_read(32'h8, rd);
      checks++;
      if (rd !== 32'h334) begin errors++; $display("FAIL sel_prescale got %h want 334", rd); end
      wb_write(32'h4, 32'h0, 4'hF);
   endtask

   task automatic test_frame;
      exp_t e;
      logic [7:0] es;
      wb_write(32'h0, tb_digits, 4'hF);
      wb_write(32'h8, 32'd3, 4'hF);
      wb_write(32'h4, 32'hFF01, 4'hF);
      tb_bright = 8'hFF;
      sb.delete();
      sb.push_back('{4'b0000, 8'h00});
      for (int d = 0; d < 4; d++) begin
         repeat (4) sb.push_back('{4'(1 << d), dbyte(d)});
         sb.push_back('{4'b0000, 8'h00});
      end
      while (sb.size() > 0) begin
         e = sb.pop_front();
         @(posedge clk); #1;
         es = gate(e.seg);
         checks += 2;
         if (den !== e.den) begin errors++; $display("FAIL frame_den got %b want %b", den, e.den); end
         if (seg !== es) begin errors++; $display("FAIL frame_seg got %h want %h", seg, es); end
      end
   endtask

   task automatic test_irq;
      logic [31:0] rd;
      wb_write(32'h4, 32'hFF02, 4'hF);
      checks++;
      if (irq !== 1'b1) begin errors++; $display("FAIL irq_set got %b want 1", irq); end
      wb_read(32'hC, rd);
      checks++;
      if (rd !== 32'h1) begin errors++; $display("FAIL status_done got %h want 1", rd); end
      wb_write(32'hC, 32'h1, 4'hF);
      checks++;
      if (irq !== 1'b0) begin errors++; $display("FAIL irq_clear got %b want 0", irq); end
      wb_read(32'hC, rd);
      checks++;
      if (rd !== 32'h0) begin errors++; $display("FAIL status_clear got %h want 0", rd); end
   endtask

   task automatic test_back_to_back;
      logic ea;
      @(posedge clk);
      @(negedge clk);
      cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 32'h0;
      for (int i = 0; i < 6; i++) ack_q_exp.push_back((i % 2) == 0);
      while (ack_q_exp.size() > 0) begin
         ea = ack_q_exp.pop_front();
         @(posedge clk); #1;
         checks++;
         if (ack !== ea) begin errors++; $display("FAIL b2b_ack got %b want %b", ack, ea); end
         if (ea) begin
            checks++;
            if (rdat !== tb_digits) begin
               errors++; $display("FAIL b2b_data got %h want %h", rdat, tb_digits);
            end
         end
      end
      cyc = 1'b0; stb = 1'b0;
   endtask

   task automatic test_bright;
      int lit = 0;
      int bad = 0;
      logic [3:0] den_or = '0;
      wb_write(32'h8, 32'd3, 4'hF);
      wb_write(32'h4, 32'h0001, 4'hF);
      tb_bright = 8'h00;
      repeat (40) begin
         @(posedge clk); #1;
         if (seg !== 8'h00) lit++;
         den_or |= den;
      end
      checks += 2;
      if (lit != 0) begin errors++; $display("FAIL bright0_seg lit %0d cycles, want 0", lit); end
      if (den_or !== 4'hF) begin errors++; $display("FAIL bright0_scan got %b want 1111", den_or); end
      wb_write(32'h4, 32'h0, 4'hF);
      wb_write(32'h8, 32'd1000, 4'hF);
      wb_write(32'h4, 32'h8001, 4'hF);
      tb_bright = 8'h80;
      @(posedge clk);
      lit = 0;
      repeat (256) begin
         @(posedge clk); #1;
         if (seg === 8'h4F) lit++;
         else if (seg !== 8'h00) bad++;
         if (den !== 4'b0001) bad++;
      end
      checks += 2;
      if (lit != 128) begin errors++; $display("FAIL bright80_lit got %0d want 128", lit); end
      if (bad != 0) begin errors++; $display("FAIL bright80_pattern got %0d bad cycles want 0", bad); end
   endtask

   task automatic test_prescale;
      wb_write(32'h4, 32'h0, 4'hF);
      wb_write(32'h8, 32'd100, 4'hF);
      wb_write(32'h4, 32'hFF01, 4'hF);
      tb_bright = 8'hFF;
      repeat (52) @(posedge clk);
      #1;
      checks++;
      if (den !== 4'b0001) begin errors++; $display("FAIL ps_before got %b want 0001", den); end
      wb_write(32'h8, 32'd10, 4'hF);
      checks++;
      if (den !== 4'b0001) begin errors++; $display("FAIL ps_write_edge got %b want 0001", den); end
      @(posedge clk); #1;
      checks++;
      if (den !== 4'b0000) begin errors++; $display("FAIL ps_terminal got %b want 0000", den); end
      @(posedge clk); #1;
      checks++;
      if (den !== 4'b0010) begin errors++; $display("FAIL ps_next got %b want 0010", den); end
   endtask

   task automatic test_prescale_zero;
      exp_t e;
      logic [7:0] es;
      wb_write(32'h4, 32'hFF00, 4'hF);
      wb_write(32'h8, 32'd0, 4'hF);
      wb_write(32'h4, 32'hFF01, 4'hF);
      sb.delete();
      sb.push_back('{4'b0000, 8'h00});
      for (int d = 0; d < 4; d++) begin
         repeat (2) sb.push_back('{4'(1 << d), dbyte(d)});
         sb.push_back('{4'b0000, 8'h00});
      end
      while (sb.size() > 0) begin
         e = sb.pop_front();
         @(posedge clk); #1;
         es = gate(e.seg);
         checks += 2;
         if (den !== e.den) begin errors++; $display("FAIL ps0_den got %b want %b", den, e.den); end
         if (seg !== es) begin errors++; $display("FAIL ps0_seg got %h want %h", seg, es); end
      end
   endtask

   task automatic test_en_clear;
      logic [31:0] rd;
      wb_write(32'h4, 32'hFF00, 4'hF);
      wb_write(32'h8, 32'd3, 4'hF);
      wb_write(32'h4, 32'hFF01, 4'hF);
      repeat (3) @(posedge clk);
      wb_write(32'h4, 32'hFF00, 4'hF);
      checks++;
      if (den !== 4'b0001) begin errors++; $display("FAIL en_show got %b want 0001", den); end
      @(posedge clk); #1;
      checks++;
      if ({den, seg} !== 12'h0) begin
         errors++; $display("FAIL en_idle got den=%b seg=%h want 0", den, seg);
      end
      wb_read(32'hC, rd);
      checks++;
      if (rd !== 32'h1) begin errors++; $display("FAIL en_status got %h want 1", rd); end
      wb_write(32'h4, 32'hFF01, 4'hF);
      @(posedge clk); #1;
      checks++;
      if (den !== 4'b0000) begin errors++; $display("FAIL reen_blank got %b want 0000", den); end
      @(posedge clk); #1;
      checks += 2;
      if (den !== 4'b0001) begin errors++; $display("FAIL reen_digit got %b want 0001", den); end
      if (seg !== gate(8'h4F)) begin
         errors++; $display("FAIL reen_seg got %h want %h", seg, gate(8'h4F));
      end
   endtask

   task automatic test_reset_mid;
      logic [31:0] rd;
      wb_write(32'h4, 32'hFF03, 4'hF);
      wb_write(32'hC, 32'h1, 4'hF);
      repeat (25) @(posedge clk);
      #1;
      checks++;
      if (irq !== 1'b1) begin errors++; $display("FAIL pre_reset_irq got %b want 1", irq); end
      @(negedge clk);
      cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 32'h0; sel = 4'hF;
      @(posedge clk); #1;
      checks += 2;
      if (ack !== 1'b1) begin errors++; $display("FAIL pre_reset_ack got %b want 1", ack); end
      if (rdat !== tb_digits) begin errors++; $display("FAIL pre_reset_dat got %h want %h", rdat, tb_digits); end
      @(negedge clk);
      we = 1'b1; wdat = 32'hDEAD_BEEF; rst_n = 1'b0;
      @(posedge clk); #1;
      checks++;
      if ({ack, rdat, seg, den, irq} !== 46'h0) begin
         errors++;
         $display("FAIL mid_reset got ack=%b dat=%h seg=%h den=%b irq=%b, required all 0",
                  ack, rdat, seg, den, irq);
      end
      @(posedge clk);
      @(negedge clk);
      cyc = 1'b0; stb = 1'b0; we = 1'b0; rst_n = 1'b1;
      wb_read(32'h0, rd);
      checks++;
      if (rd !== 32'h0) begin errors++; $display("FAIL mid_reset_digits got %h want 0", rd); end
      wb_read(32'h4, rd);
      checks++;
      if (rd !== 32'h0) begin errors++; $display("FAIL mid_reset_ctrl got %h want 0", rd); end
      wb_read(32'h8, rd);
      checks++;
      if (rd !== 32'h3E7) begin errors++; $display("FAIL mid_reset_prescale got %h want 3e7", rd); end
      wb_read(32'hC, rd);
      checks++;
      if (rd !== 32'h0) begin errors++; $display("FAIL mid_reset_status got %h want 0", rd); end
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if ({den, seg, irq} !== 13'h0) begin
         errors++; $display("FAIL post_reset_idle got den=%b seg=%h irq=%b want 0", den, seg, irq);
      end
   endtask

   initial begin
      test_reset;
      test_regs;
      test_frame;
      test_irq;
      test_back_to_back;
      test_bright;
      test_prescale;
      test_prescale_zero;
      test_en_clear;
      test_reset_mid;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
